// File: rtl/mem_lsu_if.sv
// Data-memory request/response port between the MEM-stage LSU and data memory.
// The LSU is the master; the memory (or its adapter) is the slave.
interface mem_lsu_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
    input  dm_ready, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
    output dm_ready, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues valid/ready data-memory requests, stalls
// the pipeline until completion and registers sign/zero-extended load data.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  MEM_op,
  input  logic [2:0]  MEM_func3,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_st_data,
  mem_lsu_if.master   dm,
  output logic        mem_wait,
  output logic [31:0] MEM_ld_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t      state, state_nx;
  logic        is_ld, is_st, is_mem;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign is_ld  = (MEM_op == 7'b0000011);
  assign is_st  = (MEM_op == 7'b0100011);
  assign is_mem = is_ld | is_st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // IDLE with a pending op already behaves as REQ, so acceptance can land in
  // the op's first MEM cycle without an extra bubble.
  always_comb begin
    state_nx  = state;
    dm.dm_req = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          dm.dm_req = 1'b1;
          if (dm.dm_ready) state_nx = is_st ? DONE : WAIT_R;
          else             state_nx = REQ;
        end
      end
      REQ: begin
        dm.dm_req = 1'b1;
        if (dm.dm_ready) state_nx = is_st ? DONE : WAIT_R;
      end
      WAIT_R: begin
        if (dm.dm_rvalid) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_wait = is_mem && (state != DONE);

  always_comb begin
    dm.dm_addr  = '0;
    dm.dm_we    = 1'b0;
    dm.dm_wstrb = '0;
    dm.dm_wdata = '0;
    if (is_mem) begin
      dm.dm_addr = {MEM_addr[31:2], 2'b00};
      dm.dm_we   = is_st;
    end
    if (is_st) begin
      case (MEM_func3)
        3'b000: begin
          dm.dm_wstrb = 4'b0001 << MEM_addr[1:0];
          dm.dm_wdata = {4{MEM_st_data[7:0]}};
        end
        3'b001: begin
          dm.dm_wstrb = MEM_addr[1] ? 4'b1100 : 4'b0011;
          dm.dm_wdata = {2{MEM_st_data[15:0]}};
        end
        default: begin
          dm.dm_wstrb = 4'b1111;
          dm.dm_wdata = MEM_st_data;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = dm.dm_rdata[{MEM_addr[1:0], 3'b000} +: 8];
    ld_half = dm.dm_rdata[{MEM_addr[1], 4'b0000} +: 16];
    case (MEM_func3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dm.dm_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      MEM_ld_data <= '0;
    else if (state == WAIT_R && dm.dm_rvalid && is_ld) MEM_ld_data <= ld_ext;
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: a behavioural memory answers requests with
// programmable ready/rvalid latency; expected load data is queued per op.
module tb_mem_lsu;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ADD = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  MEM_op;
  logic [2:0]  MEM_func3;
  logic [31:0] MEM_addr;
  logic [31:0] MEM_st_data;
  logic        mem_wait;
  logic [31:0] MEM_ld_data;

  mem_lsu_if dm_bus ();

  mem_lsu dut (
    .clk         (clk),
    .rst         (rst),
    .MEM_op      (MEM_op),
    .MEM_func3   (MEM_func3),
    .MEM_addr    (MEM_addr),
    .MEM_st_data (MEM_st_data),
    .dm          (dm_bus),
    .mem_wait    (mem_wait),
    .MEM_ld_data (MEM_ld_data)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_ld = '0;

  // Drives one memory op at posedge+1 and follows it to its DONE cycle.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] st,
                        input int unsigned rdly, input int unsigned vdly,
                        input logic [31:0] rdata, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_ld,
                        input bit late_ready);
    bit          is_ld;
    bit          accepted;
    int unsigned acc_c;
    int unsigned exp_wait;
    logic [31:0] exp_addr;
    logic [31:0] want;
    is_ld    = (op == OP_LD);
    accepted = 1'b0;
    acc_c    = 0;
    exp_addr = {addr[31:2], 2'b00};
    exp_wait = rdly + 1 + (is_ld ? vdly : 0);
    MEM_op = op; MEM_func3 = f3; MEM_addr = addr; MEM_st_data = st;
    if (is_ld) sb_q.push_back(exp_ld);
    for (int unsigned c = 0; ; c++) begin
      @(negedge clk);
      dm_bus.dm_ready  = 1'b0;
      dm_bus.dm_rvalid = 1'b0;
      dm_bus.dm_rdata  = $urandom;
      if (!mem_wait) begin
        tests++;
        if (c !== exp_wait) begin
          fails++; $display("FAIL wait_cycles addr=%h: got %0d expected %0d", addr, c, exp_wait);
        end
        tests++;
        if (dm_bus.dm_req !== 1'b0) begin
          fails++; $display("FAIL req_in_done addr=%h: got %b expected 0", addr, dm_bus.dm_req);
        end
        if (is_ld) begin
          if (sb_q.size() == 0) want = last_ld;
          else                  want = sb_q.pop_front();
          last_ld = want;
        end
        tests++;
        if (MEM_ld_data !== last_ld) begin
          fails++; $display("FAIL ld_data_done addr=%h: got %h expected %h", addr, MEM_ld_data, last_ld);
        end
        if (late_ready) dm_bus.dm_ready = 1'b1;
        break;
      end
      tests++;
      if (dm_bus.dm_req !== !accepted) begin
        fails++; $display("FAIL req c=%0d addr=%h: got %b expected %b", c, addr, dm_bus.dm_req, !accepted);
      end
      if (!accepted) begin
        tests++;
        if (dm_bus.dm_addr !== exp_addr || dm_bus.dm_we !== !is_ld || dm_bus.dm_wstrb !== exp_strb) begin
          fails++; $display("FAIL req_fields c=%0d: got addr=%h we=%b strb=%b expected addr=%h we=%b strb=%b",
                            c, dm_bus.dm_addr, dm_bus.dm_we, dm_bus.dm_wstrb, exp_addr, !is_ld, exp_strb);
        end
        if (!is_ld) begin
          tests++;
          if (dm_bus.dm_wdata !== exp_wdata) begin
            fails++; $display("FAIL wdata c=%0d: got %h expected %h", c, dm_bus.dm_wdata, exp_wdata);
          end
        end
      end
      tests++;
      if (MEM_ld_data !== last_ld) begin
        fails++; $display("FAIL ld_hold c=%0d addr=%h: got %h expected %h", c, addr, MEM_ld_data, last_ld);
      end
      if (!accepted && c >= rdly) begin
        dm_bus.dm_ready = 1'b1;
        accepted = 1'b1;
        acc_c = c;
      end else if (is_ld && accepted && c == acc_c + vdly) begin
        dm_bus.dm_rvalid = 1'b1;
        dm_bus.dm_rdata  = rdata;
      end
      if (c >= 60) begin
        tests++; fails++;
        $display("FAIL timeout addr=%h: mem_wait still %b after %0d cycles, expected 0", addr, mem_wait, c);
        break;
      end
    end
    @(posedge clk); #1;
    dm_bus.dm_ready = 1'b0;
  endtask

  task automatic run_nop(input int unsigned n, input bit spurious);
    MEM_op = OP_ADD; MEM_func3 = 3'b000; MEM_addr = 32'h0000_3001; MEM_st_data = 32'hFFFF_FFFF;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      dm_bus.dm_ready  = spurious;
      dm_bus.dm_rvalid = spurious;
      dm_bus.dm_rdata  = $urandom;
      tests++;
      if (mem_wait !== 1'b0 || dm_bus.dm_req !== 1'b0) begin
        fails++; $display("FAIL nop_idle i=%0d: got wait=%b req=%b expected 0 0", i, mem_wait, dm_bus.dm_req);
      end
      tests++;
      if (dm_bus.dm_addr !== '0 || dm_bus.dm_wstrb !== '0 || dm_bus.dm_we !== 1'b0 || dm_bus.dm_wdata !== '0) begin
        fails++; $display("FAIL nop_fields i=%0d: got addr=%h strb=%b we=%b wdata=%h expected all 0",
                          i, dm_bus.dm_addr, dm_bus.dm_wstrb, dm_bus.dm_we, dm_bus.dm_wdata);
      end
      tests++;
      if (MEM_ld_data !== last_ld) begin
        fails++; $display("FAIL nop_ld_hold i=%0d: got %h expected %h", i, MEM_ld_data, last_ld);
      end
    end
    @(posedge clk); #1;
    dm_bus.dm_ready  = 1'b0;
    dm_bus.dm_rvalid = 1'b0;
  endtask

  task automatic test_power_on;
    rst = 1'b1;
    MEM_op = OP_ADD; MEM_func3 = '0; MEM_addr = '0; MEM_st_data = '0;
    dm_bus.dm_ready = 1'b0; dm_bus.dm_rvalid = 1'b0; dm_bus.dm_rdata = '0;
    #2;
    tests++;
    if (MEM_ld_data !== 32'h0 || mem_wait !== 1'b0 || dm_bus.dm_req !== 1'b0) begin
      fails++; $display("FAIL power_on_reset: got ld=%h wait=%b req=%b expected 0 0 0",
                        MEM_ld_data, mem_wait, dm_bus.dm_req);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_stores;
    run_op(OP_ST, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, '0, 4'b1000, 32'hA5A5_A5A5, '0, 1'b0);
    run_nop(1, 1'b0);
    run_op(OP_ST, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 3, 0, '0, 4'b1100, 32'hBEEF_BEEF, '0, 1'b0);
    run_nop(1, 1'b0);
    run_op(OP_ST, 3'b000, 32'h0000_0010, 32'h7766_5544, 1, 0, '0, 4'b0001, 32'h4444_4444, '0, 1'b0);
    run_op(OP_ST, 3'b001, 32'h0000_6001, 32'hAAAA_5678, 0, 0, '0, 4'b0011, 32'h5678_5678, '0, 1'b0);
  endtask

  task automatic test_loads;
    run_op(OP_LD, 3'b000, 32'h0000_3001, '0, 0, 2, 32'h0000_F100, '0, '0, 32'hFFFF_FFF1, 1'b0);
    run_nop(1, 1'b0);
    run_op(OP_LD, 3'b100, 32'h0000_3001, '0, 0, 2, 32'h0000_F100, '0, '0, 32'h0000_00F1, 1'b0);
    run_op(OP_LD, 3'b101, 32'h0000_3002, '0, 1, 1, 32'h8001_1234, '0, '0, 32'h0000_8001, 1'b0);
    run_op(OP_LD, 3'b001, 32'h0000_5002, '0, 0, 3, 32'h8001_7FFF, '0, '0, 32'hFFFF_8001, 1'b0);
    run_op(OP_LD, 3'b100, 32'h0000_5003, '0, 2, 1, 32'h9C00_0000, '0, '0, 32'h0000_009C, 1'b0);
  endtask

  task automatic test_ld_hold;
    run_op(OP_LD, 3'b010, 32'h0000_4000, '0, 1, 1, 32'hDEAD_BEEF, '0, '0, 32'hDEAD_BEEF, 1'b0);
    run_nop(3, 1'b0);
    run_op(OP_ST, 3'b010, 32'h0000_4004, 32'h1122_3344, 2, 0, '0, 4'b1111, 32'h1122_3344, '0, 1'b0);
    run_nop(1, 1'b0);
  endtask

  task automatic test_spurious;
    run_nop(3, 1'b1);
    run_op(OP_ST, 3'b010, 32'h0000_8000, 32'h0BAD_F00D, 0, 0, '0, 4'b1111, 32'h0BAD_F00D, '0, 1'b1);
    run_nop(2, 1'b1);
  endtask

  task automatic test_back_to_back;
    run_op(OP_ST, 3'b000, 32'h0000_9002, 32'h0000_0033, 0, 0, '0, 4'b0100, 32'h3333_3333, '0, 1'b0);
    run_op(OP_LD, 3'b010, 32'h0000_9004, '0, 0, 1, 32'h0102_0304, '0, '0, 32'h0102_0304, 1'b0);
    run_op(OP_LD, 3'b001, 32'h0000_9000, '0, 0, 1, 32'h1111_7ABC, '0, '0, 32'h0000_7ABC, 1'b0);
    run_op(OP_ST, 3'b001, 32'h0000_9000, 32'h0000_CDEF, 1, 0, '0, 4'b0011, 32'hCDEF_CDEF, '0, 1'b0);
  endtask

  task automatic test_reset;
    run_op(OP_LD, 3'b010, 32'h0000_7000, '0, 0, 1, 32'hCAFE_F00D, '0, '0, 32'hCAFE_F00D, 1'b0);
    MEM_op = OP_LD; MEM_func3 = 3'b010; MEM_addr = 32'h0000_7004;
    @(negedge clk);
    dm_bus.dm_ready = 1'b1;
    @(posedge clk); #1;
    dm_bus.dm_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (dm_bus.dm_req !== 1'b0 || mem_wait !== 1'b1) begin
      fails++; $display("FAIL wait_r_state: got req=%b wait=%b expected 0 1", dm_bus.dm_req, mem_wait);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (MEM_ld_data !== 32'h0) begin
      fails++; $display("FAIL reset_ld_data: got %h expected 00000000", MEM_ld_data);
    end
    tests++;
    if (dm_bus.dm_req !== 1'b1) begin
      fails++; $display("FAIL reset_to_idle: req got %b expected 1", dm_bus.dm_req);
    end
    MEM_op = OP_ADD;
    #1;
    tests++;
    if (mem_wait !== 1'b0 || dm_bus.dm_req !== 1'b0) begin
      fails++; $display("FAIL reset_nop: got wait=%b req=%b expected 0 0", mem_wait, dm_bus.dm_req);
    end
    last_ld = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_nop(2, 1'b0);
    run_op(OP_LD, 3'b100, 32'h0000_7002, '0, 0, 1, 32'h00AB_0000, '0, '0, 32'h0000_00AB, 1'b0);
  endtask

  initial begin
    test_power_on();
    test_stores();
    test_loads();
    test_ld_hold();
    test_spurious();
    test_back_to_back();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
